// File: rtl/tx_control.sv
// Transmit sequencer: captures the ALU result and feeds it to uart_tx one byte per frame, LSB first.
// Optional build macro TX_CHECKSUM_EN appends an XOR checksum byte after the result bytes.
`timescale 1ns/1ps

module tx_control #(
  parameter int NBYTES      = 2,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_tx_start,
  input  logic [8*NBYTES-1:0]   i_result,
  input  logic                  i_tx_busy,
  output logic [7:0]            o_tx_data,
  output logic                  o_tx_send,
  output logic                  o_active,
  output logic                  o_done
);

`ifdef TX_CHECKSUM_EN
  localparam int NTOT = NBYTES + 1;
`else
  localparam int NTOT = NBYTES;
`endif
  localparam int IW = $clog2(NTOT + 1);
  localparam int CW = $clog2(ACK_TIMEOUT + 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(NTOT - 1);
  localparam logic [CW-1:0] CNT_TC   = CW'(ACK_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEND,
    S_WAIT_ACK,
    S_WAIT_DONE,
    S_DONE
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [8*NTOT-1:0]   r_shift;
  logic [8*NTOT-1:0]   w_capture;
  logic [IW-1:0]       r_idx;
  logic [CW-1:0]       r_cnt;
  logic [7:0]          r_tx_data;
  logic                r_tx_send;
  logic                w_load;
  logic                w_issue;
  logic                w_advance;
  logic                w_cnt_inc;

`ifdef TX_CHECKSUM_EN
  logic [7:0] w_csum;

  always_comb begin
    w_csum = '0;
    for (int k = 0; k < NBYTES; k++) begin
      w_csum = w_csum ^ i_result[8*k +: 8];
    end
  end

  // Checksum rides in the top byte of the shift register so it leaves last.
  assign w_capture = {w_csum, i_result};
`else
  assign w_capture = i_result;
`endif

  always_comb begin
    w_next    = r_state;
    w_load    = 1'b0;
    w_issue   = 1'b0;
    w_advance = 1'b0;
    w_cnt_inc = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_tx_start) begin
          w_load = 1'b1;
          w_next = S_SEND;
        end
      end
      S_SEND: begin
        if (!i_tx_busy) begin
          w_issue = 1'b1;
          w_next  = S_WAIT_ACK;
        end
      end
      S_WAIT_ACK: begin
        if (i_tx_busy) begin
          w_next = S_WAIT_DONE;
        end else if (r_cnt == CNT_TC) begin
          w_next = S_SEND;
        end else begin
          w_cnt_inc = 1'b1;
        end
      end
      S_WAIT_DONE: begin
        if (!i_tx_busy) begin
          if (r_idx == LAST_IDX) begin
            w_next = S_DONE;
          end else begin
            w_advance = 1'b1;
            w_next    = S_SEND;
          end
        end
      end
      S_DONE: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state   <= S_IDLE;
      r_shift   <= '0;
      r_idx     <= '0;
      r_cnt     <= '0;
      r_tx_data <= 8'h00;
      r_tx_send <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_tx_send <= w_issue;
      // tx_data and tx_send change on the same edge so uart_tx sees them aligned.
      if (w_issue) begin
        r_tx_data <= r_shift[7:0];
        r_cnt     <= '0;
      end else if (w_cnt_inc) begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (w_load) begin
        r_shift <= w_capture;
        r_idx   <= '0;
      end else if (w_advance) begin
        r_shift <= r_shift >> 8;
        r_idx   <= r_idx + 1'b1;
      end
    end
  end

  assign o_tx_data = r_tx_data;
  assign o_tx_send = r_tx_send;
  assign o_active  = (r_state != S_IDLE);
  assign o_done    = (r_state == S_DONE);

endmodule
